// File: rtl/ysyx_22040127_mem_stage.sv
// Memory-access pipeline stage: latches the execute bus, issues one data-memory
// request per load/store over a valid/ready channel, waits for the response, then
// aligns and extends load data before handing the result to writeback.
module ysyx_22040127_mem_stage #(
    parameter int unsigned EX_TO_MEM_WIDTH = 262,
    parameter int unsigned MEM_TO_WB_WIDTH = 193
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_to_mem_valid,
    output logic                       mem_allowin,
    input  logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_bus,
    input  logic                       wb_allowin,
    output logic                       mem_to_wb_valid,
    output logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_bus,
    output logic                       mem_mret,
    output logic                       dm_req_valid,
    input  logic                       dm_req_ready,
    output logic                       dm_req_we,
    output logic [63:0]                dm_addr,
    output logic [63:0]                dm_wdata,
    output logic [7:0]                 dm_wmask,
    input  logic                       dm_resp_valid,
    input  logic [63:0]                dm_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e                     state_q, state_d;
    logic                       mem_valid_q;
    logic [EX_TO_MEM_WIDTH-1:0] bus_q;
    logic [63:0]                rdata_q;

    logic        latch;
    logic        in_is_mem;
    logic        handoff;
    logic        mem_ready_go;
    logic        is_mem;
    logic [2:0]  memop;
    logic [1:0]  size;
    logic        zext;
    logic        memread;
    logic        memwrite;
    logic [63:0] addr;
    logic [63:0] st_data;
    logic [2:0]  off;
    logic [5:0]  shamt;
    logic [7:0]  mask_base;
    logic [63:0] ld_sh;
    logic [63:0] ld_ext;
    logic [63:0] result;

    // Field decode of the latched bus
    assign memop    = bus_q[138:136];
    assign size     = memop[1:0];
    assign zext     = memop[2];
    assign memwrite = bus_q[134];
    assign memread  = bus_q[133];
    assign addr     = bus_q[127:64];
    assign st_data  = bus_q[63:0];
    assign off      = addr[2:0];
    assign shamt    = {off, 3'b000};
    assign is_mem   = memread | memwrite;

    assign in_is_mem = ex_to_mem_bus[134] | ex_to_mem_bus[133];
    assign latch     = ex_to_mem_valid & mem_allowin;
    assign handoff   = mem_to_wb_valid & wb_allowin;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Pipeline valid, bus register and captured read data
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
            bus_q       <= '0;
            rdata_q     <= '0;
        end else begin
            if (mem_allowin) begin
                mem_valid_q <= ex_to_mem_valid;
            end
            if (latch) begin
                bus_q <= ex_to_mem_bus;
            end
            // Responses outside WAIT (including after a reset) are ignored
            if (state_q == StWait && dm_resp_valid) begin
                rdata_q <= dm_rdata;
            end
        end
    end

    // Next-state logic; a new latch overrides so DONE can go straight to REQ
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: state_d = StIdle;
            StReq:  if (dm_req_ready) state_d = StWait;
            StWait: if (dm_resp_valid) state_d = StDone;
            StDone: if (handoff) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (latch) begin
            state_d = in_is_mem ? StReq : StIdle;
        end
    end

    // Handshakes, request fields and load alignment
    always_comb begin
        mem_ready_go    = !is_mem || (state_q == StDone);
        mem_to_wb_valid = mem_valid_q & mem_ready_go;
        mem_allowin     = !mem_valid_q || (mem_ready_go && wb_allowin);
        mem_mret        = mem_valid_q & bus_q[179];

        dm_req_valid = (state_q == StReq);
        dm_req_we    = memwrite;
        dm_addr      = {addr[63:3], 3'b000};
        dm_wdata     = st_data << shamt;

        mask_base = 8'h01;
        unique case (size)
            2'b00: mask_base = 8'h01;
            2'b01: mask_base = 8'h03;
            2'b10: mask_base = 8'h0F;
            2'b11: mask_base = 8'hFF;
            default: mask_base = 8'h01;
        endcase
        // Lanes past byte 7 fall off the top
        dm_wmask = mask_base << off;

        ld_sh  = rdata_q >> shamt;
        ld_ext = ld_sh;
        unique case (size)
            2'b00: ld_ext = {{56{~zext & ld_sh[7]}}, ld_sh[7:0]};
            2'b01: ld_ext = {{48{~zext & ld_sh[15]}}, ld_sh[15:0]};
            2'b10: ld_ext = {{32{~zext & ld_sh[31]}}, ld_sh[31:0]};
            2'b11: ld_ext = ld_sh;
            default: ld_ext = ld_sh;
        endcase

        result = memread ? ld_ext : addr;
        mem_to_wb_bus = {bus_q[261:171], bus_q[170:139], bus_q[135], bus_q[132:128], result};
    end

endmodule

// File: tb/tb_ysyx_22040127_mem_stage.sv
// Directed bench for the memory stage: a vector table of single transactions
// plus hand-written sequences for back-to-back, backpressure and reset cases.
module tb_ysyx_22040127_mem_stage;

    logic         clk;
    logic         rst;
    logic         ex_to_mem_valid;
    logic         mem_allowin;
    logic [261:0] ex_to_mem_bus;
    logic         wb_allowin;
    logic         mem_to_wb_valid;
    logic [192:0] mem_to_wb_bus;
    logic         mem_mret;
    logic         dm_req_valid;
    logic         dm_req_ready;
    logic         dm_req_we;
    logic [63:0]  dm_addr;
    logic [63:0]  dm_wdata;
    logic [7:0]   dm_wmask;
    logic         dm_resp_valid;
    logic [63:0]  dm_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    ysyx_22040127_mem_stage #(
        .EX_TO_MEM_WIDTH(262),
        .MEM_TO_WB_WIDTH(193)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_to_mem_valid(ex_to_mem_valid),
        .mem_allowin    (mem_allowin),
        .ex_to_mem_bus  (ex_to_mem_bus),
        .wb_allowin     (wb_allowin),
        .mem_to_wb_valid(mem_to_wb_valid),
        .mem_to_wb_bus  (mem_to_wb_bus),
        .mem_mret       (mem_mret),
        .dm_req_valid   (dm_req_valid),
        .dm_req_ready   (dm_req_ready),
        .dm_req_we      (dm_req_we),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_wmask       (dm_wmask),
        .dm_resp_valid  (dm_resp_valid),
        .dm_rdata       (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [90:0] pass;
        logic [31:0] pc;
        logic [2:0]  memop;
        logic        rw;
        logic        mw;
        logic        mr;
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic [7:0]  e_wmask;
        logic [63:0] e_result;
        logic        e_mret;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [192:0] act, input logic [192:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [261:0] mk_bus(input logic [90:0] pass, input logic [31:0] pc,
                                            input logic [2:0] memop, input logic rw,
                                            input logic mw, input logic mr,
                                            input logic [4:0] rd, input logic [63:0] alu,
                                            input logic [63:0] wdata);
        return {pass, pc, memop, rw, mw, mr, rd, alu, wdata};
    endfunction

    function automatic vec_t mkv(input string name, input logic [90:0] pass,
                                 input logic [31:0] pc, input logic [2:0] memop,
                                 input logic rw, input logic mw, input logic mr,
                                 input logic [4:0] rd, input logic [63:0] alu,
                                 input logic [63:0] wdata, input logic [63:0] rdata,
                                 input logic [63:0] e_addr, input logic [63:0] e_wdata,
                                 input logic [7:0] e_wmask, input logic [63:0] e_result,
                                 input logic e_mret);
        vec_t v;
        v.name = name; v.pass = pass; v.pc = pc; v.memop = memop; v.rw = rw; v.mw = mw;
        v.mr = mr; v.rd = rd; v.alu = alu; v.wdata = wdata; v.rdata = rdata;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wmask = e_wmask;
        v.e_result = e_result; v.e_mret = e_mret;
        return v;
    endfunction

    // One transaction from an idle stage, handed off with wb_allowin high
    task automatic run_vec(input vec_t v);
        logic [192:0] exp_bus;
        exp_bus = {v.pass, v.pc, v.rw, v.rd, v.e_result};
        ex_to_mem_bus   = mk_bus(v.pass, v.pc, v.memop, v.rw, v.mw, v.mr, v.rd, v.alu, v.wdata);
        ex_to_mem_valid = 1'b1;
        wb_allowin      = 1'b1;
        @(posedge clk); #1;
        ex_to_mem_valid = 1'b0;
        if (v.mw || v.mr) begin
            dm_req_ready = 1'b1;
            @(negedge clk);
            chk({v.name, "_req_valid"}, 193'(dm_req_valid), 193'(1'b1));
            chk({v.name, "_addr"}, 193'(dm_addr), 193'(v.e_addr));
            chk({v.name, "_wdata"}, 193'(dm_wdata), 193'(v.e_wdata));
            chk({v.name, "_wmask"}, 193'(dm_wmask), 193'(v.e_wmask));
            chk({v.name, "_we"}, 193'(dm_req_we), 193'(v.mw));
            @(posedge clk); #1;
            dm_req_ready = 1'b0;
            @(negedge clk);
            chk({v.name, "_wait_valid"}, 193'({mem_to_wb_valid, dm_req_valid}), 193'(2'b00));
            dm_resp_valid = 1'b1;
            dm_rdata      = v.rdata;
            @(posedge clk); #1;
            dm_resp_valid = 1'b0;
            dm_rdata      = 64'h0;
        end
        @(negedge clk);
        chk({v.name, "_valid"}, 193'(mem_to_wb_valid), 193'(1'b1));
        chk({v.name, "_bus"}, mem_to_wb_bus, exp_bus);
        chk({v.name, "_mret"}, 193'(mem_mret), 193'(v.e_mret));
        @(posedge clk); #1;
        @(negedge clk);
        chk({v.name, "_after"}, 193'({mem_to_wb_valid, mem_allowin}), 193'(2'b01));
    endtask

    initial begin
        logic [192:0] exp_bus;

        vecs[0]  = mkv("add", 91'h100, 32'h80000100, 3'b000, 1, 0, 0, 5'd5, 64'h1234, 64'h0,
                       64'h0, 64'h0, 64'h0, 8'h01, 64'h1234, 1);
        vecs[1]  = mkv("lb", 91'h0, 32'h80000104, 3'b000, 1, 0, 1, 5'd6, 64'h80000003, 64'h0,
                       64'h0000000080FF0000, 64'h80000000, 64'h0, 8'h08,
                       64'hFFFFFFFFFFFFFF80, 0);
        vecs[2]  = mkv("lbu", 91'h0, 32'h80000108, 3'b100, 1, 0, 1, 5'd7, 64'h80000003, 64'h0,
                       64'h0000000080FF0000, 64'h80000000, 64'h0, 8'h08, 64'h80, 0);
        vecs[3]  = mkv("sh", 91'h0, 32'h8000010C, 3'b001, 0, 1, 0, 5'd0, 64'h80000006,
                       64'hABCD, 64'h0, 64'h80000000, 64'hABCD000000000000, 8'hC0,
                       64'h80000006, 0);
        vecs[4]  = mkv("lw_neg", 91'h0, 32'h80000110, 3'b010, 1, 0, 1, 5'd8, 64'h80000000,
                       64'h0, 64'h1234567880000000, 64'h80000000, 64'h0, 8'h0F,
                       64'hFFFFFFFF80000000, 0);
        vecs[5]  = mkv("lhu", 91'h0, 32'h80000114, 3'b101, 1, 0, 1, 5'd9, 64'h80000002, 64'h0,
                       64'h11112222F00D3333, 64'h80000000, 64'h0, 8'h0C, 64'hF00D, 0);
        vecs[6]  = mkv("lh", 91'h0, 32'h80000118, 3'b001, 1, 0, 1, 5'd10, 64'h80000002, 64'h0,
                       64'h11112222F00D3333, 64'h80000000, 64'h0, 8'h0C,
                       64'hFFFFFFFFFFFFF00D, 0);
        vecs[7]  = mkv("ld", 91'h0, 32'h8000011C, 3'b011, 1, 0, 1, 5'd11, 64'h80000008, 64'h0,
                       64'hDEADBEEFCAFEF00D, 64'h80000008, 64'h0, 8'hFF,
                       64'hDEADBEEFCAFEF00D, 0);
        vecs[8]  = mkv("sb", 91'h0, 32'h80000120, 3'b000, 0, 1, 0, 5'd0, 64'h80000005,
                       64'h11223344556677EF, 64'h0, 64'h80000000, 64'h6677EF0000000000,
                       8'h20, 64'h80000005, 0);
        vecs[9]  = mkv("lwu", 91'h0, 32'h80000124, 3'b110, 1, 0, 1, 5'd12, 64'h80000004, 64'h0,
                       64'h89ABCDEF01234567, 64'h80000000, 64'h0, 8'hF0, 64'h89ABCDEF, 0);
        vecs[10] = mkv("sw", 91'h0, 32'h80000128, 3'b010, 0, 1, 0, 5'd0, 64'h80000004,
                       64'hCAFEBABE, 64'h0, 64'h80000000, 64'hCAFEBABE00000000, 8'hF0,
                       64'h80000004, 0);

        rst             = 1'b1;
        ex_to_mem_valid = 1'b0;
        ex_to_mem_bus   = '0;
        wb_allowin      = 1'b1;
        dm_req_ready    = 1'b0;
        dm_resp_valid   = 1'b0;
        dm_rdata        = 64'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_allowin", 193'(mem_allowin), 193'(1'b1));
        chk("rst_valid", 193'({mem_to_wb_valid, dm_req_valid, mem_mret, dm_req_we}), 193'(0));
        chk("rst_wmask", 193'(dm_wmask), 193'(8'h01));
        chk("rst_bus", mem_to_wb_bus, 193'(0));
        chk("rst_addr_wdata", 193'({dm_addr, dm_wdata}), 193'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Three back-to-back ALU ops, one per cycle
        wb_allowin      = 1'b1;
        ex_to_mem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_to_mem_bus = mk_bus(91'h0, 32'h80000200 + 32'(4 * i), 3'b000, 1, 0, 0,
                                   5'(i + 1), 64'(32'h100 + i), 64'h0);
            @(posedge clk); #1;
            if (i == 2) ex_to_mem_valid = 1'b0;
            @(negedge clk);
            exp_bus = {91'h0, 32'h80000200 + 32'(4 * i), 1'b1, 5'(i + 1), 64'(32'h100 + i)};
            chk("b2b_valid", 193'({mem_to_wb_valid, mem_allowin}), 193'(2'b11));
            chk("b2b_bus", mem_to_wb_bus, exp_bus);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_drain", 193'(mem_to_wb_valid), 193'(1'b0));

        // Backpressured lw, then DONE stall with an sd queued behind it
        ex_to_mem_bus   = mk_bus(91'h0, 32'h80000300, 3'b010, 1, 0, 1, 5'd13, 64'h80000020,
                                 64'h0);
        ex_to_mem_valid = 1'b1;
        @(posedge clk); #1;
        ex_to_mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_req_hold", 193'({dm_req_valid, dm_addr, dm_wmask, mem_to_wb_valid}),
                193'({1'b1, 64'h80000020, 8'h0F, 1'b0}));
            @(posedge clk); #1;
        end
        dm_req_ready = 1'b1;
        @(posedge clk); #1;
        dm_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_wait", 193'({mem_to_wb_valid, dm_req_valid, mem_allowin}), 193'(3'b000));
            @(posedge clk); #1;
        end
        dm_resp_valid = 1'b1;
        dm_rdata      = 64'h000000007FFFFFFF;
        @(posedge clk); #1;
        dm_resp_valid   = 1'b0;
        dm_rdata        = 64'hFFFFFFFFFFFFFFFF;
        wb_allowin      = 1'b0;
        ex_to_mem_bus   = mk_bus(91'h0, 32'h80000304, 3'b011, 0, 1, 0, 5'd0, 64'h80000018,
                                 64'h0123456789ABCDEF);
        ex_to_mem_valid = 1'b1;
        exp_bus = {91'h0, 32'h80000300, 1'b1, 5'd13, 64'h000000007FFFFFFF};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_ctl", 193'({mem_to_wb_valid, mem_allowin, dm_req_valid}), 193'(3'b100));
            chk("stall_bus", mem_to_wb_bus, exp_bus);
            dm_resp_valid = (i == 1);
            @(posedge clk); #1;
            dm_resp_valid = 1'b0;
        end
        wb_allowin = 1'b1;
        @(posedge clk); #1;
        ex_to_mem_valid = 1'b0;
        @(negedge clk);
        chk("sd_req", 193'({dm_req_valid, dm_req_we, dm_wmask, dm_addr, mem_to_wb_valid}),
            193'({1'b1, 1'b1, 8'hFF, 64'h80000018, 1'b0}));
        chk("sd_wdata", 193'(dm_wdata), 193'(64'h0123456789ABCDEF));
        dm_req_ready = 1'b1;
        @(posedge clk); #1;
        dm_req_ready  = 1'b0;
        dm_resp_valid = 1'b1;
        @(posedge clk); #1;
        dm_resp_valid = 1'b0;
        @(negedge clk);
        chk("sd_done", mem_to_wb_bus, {91'h0, 32'h80000304, 1'b0, 5'd0, 64'h80000018});
        chk("sd_valid", 193'(mem_to_wb_valid), 193'(1'b1));
        @(posedge clk); #1;

        // Reset while in WAIT, then a stray response
        ex_to_mem_bus   = mk_bus(91'h0, 32'h80000400, 3'b011, 1, 0, 1, 5'd14, 64'h80000030,
                                 64'h0);
        ex_to_mem_valid = 1'b1;
        dm_req_ready    = 1'b1;
        @(posedge clk); #1;
        ex_to_mem_valid = 1'b0;
        @(posedge clk); #1;
        dm_req_ready = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_state", 193'({mem_to_wb_valid, dm_req_valid, mem_allowin}), 193'(3'b001));
        dm_resp_valid = 1'b1;
        dm_rdata      = 64'h5555AAAA5555AAAA;
        @(posedge clk); #1;
        dm_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rstw_late_resp", 193'({mem_to_wb_valid, dm_req_valid}), 193'(2'b00));
            @(posedge clk); #1;
        end
        chk("rstw_bus", mem_to_wb_bus, 193'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040127_mem_stage.md
# ysyx_22040127_mem_stage

Memory-access pipeline stage between execute and writeback. Latches the execute-to-memory bus and issues at most one data-memory request per load/store over a valid/ready request channel. Waits for the response, then aligns and sign/zero-extends load data. Non-memory instructions pass through in one cycle; CSR/control fields are forwarded unchanged to writeback.

## Interface
- `EX_TO_MEM_WIDTH`, 262: input bus width.
- `MEM_TO_WB_WIDTH`, 193: output bus width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_to_mem_valid` in 1: upstream holds a valid instruction.
- `mem_allowin` out 1: stage can accept this cycle.
- `ex_to_mem_bus` in 262: input bus. Fields:
  - [261:171] CSR/jalr pass-through; bit 179 is mret.
  - [170:139] pc.
  - [138:136] memop.
  - [135] reg_wen.
  - [134] memwrite.
  - [133] memread.
  - [132:128] rd.
  - [127:64] alu_result / address.
  - [63:0] store data.
- `wb_allowin` in 1: writeback can accept.
- `mem_to_wb_valid` out 1: result valid for writeback.
- `mem_to_wb_bus` out 193: {pass-through[90:0], pc[31:0], reg_wen, rd[4:0], result[63:0]}.
- `mem_mret` out 1: mem_valid & latched bit 179.
- `dm_req_valid` out 1: memory request.
- `dm_req_ready` in 1: request accepted this cycle.
- `dm_req_we` out 1: 1 = store.
- `dm_addr` out 64: {addr[63:3], 3'b000}.
- `dm_wdata` out 64: lane-shifted store data.
- `dm_wmask` out 8: byte-enable mask.
- `dm_resp_valid` in 1: response/ack, one cycle.
- `dm_rdata` in 64: read doubleword, valid with resp.

## Operation
- Latch: on `ex_to_mem_valid && mem_allowin`:
  - bus register loads the input bus;
  - `mem_valid` loads `ex_to_mem_valid`;
  - if memread|memwrite, FSM goes to REQ, otherwise to IDLE.
- `mem_allowin` = !mem_valid | (mem_ready_go & wb_allowin).
- `mem_to_wb_valid` = mem_valid & mem_ready_go.
- `mem_ready_go` = 1 when the latched op is neither a load nor a store, or when the FSM is in DONE.
- FSM states:
  - IDLE: no request.
  - REQ: `dm_req_valid`=1. Advances to WAIT on `dm_req_ready`.
  - WAIT: on `dm_resp_valid`, latch `dm_rdata` into rdata_q and go to DONE.
  - DONE: hold until handoff. On handoff, go to IDLE, or to REQ if the same edge latches a new memory op.
- Request fields are stable throughout REQ. Stores also wait for the response ack.
- Sizes: memop[1:0] gives size (00 B, 01 H, 10 W, 11 D). memop[2] marks a zero-extended load (lbu/lhu/lwu).
- Store lanes:
  - off = addr[2:0];
  - `dm_wdata` = wdata << (off*8);
  - `dm_wmask` = {1,3,15,255}[size] << off, truncated to 8 bits.
- Load data:
  - sh = rdata_q >> (off*8);
  - extend sh from bit 7, 15 or 31 (doubleword unchanged): sign-extend when memop[2]=0, zero-extend when memop[2]=1.
- Accesses are naturally aligned. Accesses crossing an 8-byte boundary are out of scope; lanes beyond byte 7 are dropped, with no trap.
- Result is the extended load data for loads, alu_result otherwise.
- reg_wen, rd and pc pass through.
- Reset: FSM=IDLE, mem_valid=0, bus register cleared. A reset mid-request drops the request immediately; any later response is ignored while IDLE.

## Timing
- Reset values: `mem_allowin`=1; every other output is 0. With the bus register cleared, `dm_wmask`=8'h01 and `mem_to_wb_bus`=0.
- Non-memory op: latched at edge T, valid to writeback during cycle T, handed off at edge T+1 if `wb_allowin`. Throughput is 1 per cycle.
- Memory op with ready=1 and 1-cycle response:
  - cycle T: REQ;
  - cycle T+1: WAIT, response arrives;
  - cycle T+2: DONE, valid.
  - Occupancy is 3 cycles.
- `wb_allowin`=0 in DONE holds the result, rdata_q and the bus register. No new request is issued.
- Simultaneous handoff and new latch in DONE: the next op enters REQ on the same edge, with no bubble state.
- `dm_resp_valid` outside WAIT is ignored.

## Test plan
- ALU pass-through: add result 0x1234, rd=5, `wb_allowin`=1 → `mem_to_wb_valid` the cycle after the latch edge, result 0x1234. Three back-to-back ops accepted one per cycle.
- lb: addr 0x80000003, rdata 0x00000000_80FF0000 → `dm_addr` 0x80000000, result 0xFFFFFFFFFFFFFF80. lbu, same data → 0x80.
- sh: addr 0x80000006, wdata 0xABCD → `dm_wmask` 0xC0, `dm_wdata` 0xABCD000000000000, `dm_req_we`=1. Stage not valid before the ack.
- Backpressure: `dm_req_ready` low for 3 cycles, then response after 2 cycles → `dm_req_valid` held with stable fields. A load of 0x7FFFFFFF (lw, off 0) gives 0x000000007FFFFFFF.
- `wb_allowin`=0 for 4 cycles in DONE → output stable, `mem_allowin`=0. On release, a queued sd enters REQ on the handoff edge.
- `rst` asserted in WAIT → next cycle FSM IDLE, `mem_to_wb_valid`=0. A late `dm_resp_valid` does not produce output.
